// File: rtl/bpc_pkg.sv
// bpc_pkg: shared widths and the unpacker state encoding for the BPC decode path.
package bpc_pkg;
    localparam int BPC_WORD_W    = 64;
    localparam int BPC_WIN_W     = 152;
    localparam int BPC_MAX_WORDS = 8;
    localparam int BPC_MAX_BITS  = BPC_MAX_WORDS * BPC_WORD_W;
    localparam int BPC_BUF_W     = 256;
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} unpack_state_e;
endpackage

// File: rtl/bpc_stream_unpack_if.sv
// bpc_stream_unpack_if: size/word input handshakes and the code-window port of the unpacker.
interface bpc_stream_unpack_if;
    import bpc_pkg::*;
    logic [10:0]           size_i;
    logic                  size_valid_i;
    logic                  size_ready_o;
    logic [BPC_WORD_W-1:0] data_i;
    logic                  data_valid_i;
    logic                  data_ready_o;
    logic [BPC_WIN_W-1:0]  window_o;
    logic [7:0]            avail_o;
    logic                  win_valid_o;
    logic                  take_i;
    logic [7:0]            consume_i;
    logic                  done_o;
    logic                  err_o;
    modport slave (
        input  size_i, size_valid_i, data_i, data_valid_i, take_i, consume_i,
        output size_ready_o, data_ready_o, window_o, avail_o, win_valid_o, done_o, err_o
    );
    modport master (
        output size_i, size_valid_i, data_i, data_valid_i, take_i, consume_i,
        input  size_ready_o, data_ready_o, window_o, avail_o, win_valid_o, done_o, err_o
    );
endinterface

// File: rtl/bpc_shift_merge.sv
// bpc_shift_merge: left-shifts the bit buffer by the consumed count and ORs a new word in at a bit offset from the top.
module bpc_shift_merge
    import bpc_pkg::*;
(
    input  logic [BPC_BUF_W-1:0]  buf_i,
    input  logic [7:0]            shamt_i,
    input  logic [BPC_WORD_W-1:0] word_i,
    input  logic                  ins_i,
    input  logic [8:0]            off_i,
    output logic [BPC_BUF_W-1:0]  buf_o
);
    always_comb
        buf_o = (buf_i << shamt_i) |
                (ins_i ? ({word_i, {(BPC_BUF_W-BPC_WORD_W){1'b0}}} >> off_i) : '0);
endmodule

// File: rtl/bpc_stream_unpack.sv
// bpc_stream_unpack: turns a sized block of packed 64-bit words into a top-aligned window
// of unconsumed code bits for the BPC symbol decoder.
module bpc_stream_unpack
    import bpc_pkg::*;
(
    input logic                clk,
    input logic                rst,
    bpc_stream_unpack_if.slave bus
);
    unpack_state_e        state_q, state_d;
    logic [BPC_BUF_W-1:0] buf_q, buf_d, merged;
    logic [8:0]           buf_bits_q, buf_bits_d, ins_off;
    logic [9:0]           bits_left_q, bits_left_d, bits_rem, size_clamp, lim;
    logic [3:0]           words_left_q, words_left_d;
    logic                 err_q, err_d, rdy_q;
    logic                 size_hs, accept, take_ok, over, finish, win_valid, data_ready;
    logic [7:0]           avail, cons;

    always_comb begin
        lim        = ({1'b0, buf_bits_q} < bits_left_q) ? {1'b0, buf_bits_q} : bits_left_q;
        avail      = (lim > 10'(BPC_WIN_W)) ? 8'(BPC_WIN_W) : lim[7:0];
        win_valid  = state_q == ACTIVE && bits_left_q != 0 &&
                     (avail == 8'(BPC_WIN_W) || {1'b0, buf_bits_q} >= bits_left_q);
        data_ready = state_q == ACTIVE && words_left_q != 0 &&
                     buf_bits_q <= 9'(BPC_BUF_W - BPC_WORD_W);
        size_hs    = rdy_q & bus.size_valid_i;
        accept     = data_ready & bus.data_valid_i;
        take_ok    = bus.take_i & win_valid;
        over       = take_ok && bus.consume_i > avail;
        cons       = take_ok ? (over ? avail : bus.consume_i) : 8'd0;
        ins_off    = buf_bits_q - {1'b0, cons};
        bits_rem   = bits_left_q - {2'b0, cons};
        finish     = state_q == ACTIVE && bits_rem == 0;
        size_clamp = (bus.size_i > 11'(BPC_MAX_BITS)) ? 10'(BPC_MAX_BITS) : bus.size_i[9:0];
    end

    bpc_shift_merge u_merge (
        .buf_i   (buf_q),
        .shamt_i (cons),
        .word_i  (bus.data_i),
        .ins_i   (accept),
        .off_i   (ins_off),
        .buf_o   (merged)
    );

    // Once the last code bit is gone, pad bits of the final word are dropped with the buffer.
    always_comb begin
        buf_d        = (size_hs || finish) ? '0 : merged;
        buf_bits_d   = (size_hs || finish) ? 9'd0 :
                       ins_off + (accept ? 9'(BPC_WORD_W) : 9'd0);
        bits_left_d  = size_hs ? size_clamp : bits_rem;
        words_left_d = size_hs ? 4'((size_clamp + 10'd63) >> 6) : words_left_q - {3'b0, accept};
        err_d        = size_hs ? bus.size_i > 11'(BPC_MAX_BITS) : err_q | over;
    end

    always_comb
        state_d = state_q == DONE   ? IDLE :
                  state_q == ACTIVE ? (finish ? DONE : ACTIVE) :
                  size_hs           ? (bus.size_i == 0 ? DONE : ACTIVE) : IDLE;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q      <= IDLE;
            rdy_q        <= 1'b0;
            buf_q        <= '0;
            buf_bits_q   <= '0;
            bits_left_q  <= '0;
            words_left_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdy_q        <= state_d == IDLE;
            buf_q        <= buf_d;
            buf_bits_q   <= buf_bits_d;
            bits_left_q  <= bits_left_d;
            words_left_q <= words_left_d;
            err_q        <= err_d;
        end

    always_comb begin
        bus.size_ready_o = rdy_q;
        bus.data_ready_o = data_ready;
        bus.win_valid_o  = win_valid;
        bus.avail_o      = avail;
        bus.window_o     = buf_q[BPC_BUF_W-1 -: BPC_WIN_W] & ~({BPC_WIN_W{1'b1}} >> avail);
        bus.done_o       = state_q == DONE;
        bus.err_o        = err_q;
    end
endmodule
